// File: rtl/mem_reader_if.sv
// Read-side bundle of mem_reader: start/abort control, memory read port,
// output word stream and status.
interface mem_reader_if #(
    parameter int C_WORDSIZE = 8,
    parameter int C_MEMSIZE  = 4096,
    parameter int C_ADDRSIZE = $clog2(C_MEMSIZE)
);
    logic                  I_start;
    logic [C_ADDRSIZE-1:0] I_base;
    logic [C_ADDRSIZE:0]   I_len;
    logic                  I_abort;
    logic [C_ADDRSIZE-1:0] O_addr;
    logic [C_WORDSIZE-1:0] I_rdata;
    logic [C_WORDSIZE-1:0] O_word;
    logic                  O_valid;
    logic                  I_ready;
    logic                  O_busy;
    logic                  O_done;
    logic [C_WORDSIZE-1:0] O_xor;

    modport master (
        input  I_start, I_base, I_len, I_abort, I_rdata, I_ready,
        output O_addr, O_word, O_valid, O_busy, O_done, O_xor
    );

    modport slave (
        output I_start, I_base, I_len, I_abort, I_rdata, I_ready,
        input  O_addr, O_word, O_valid, O_busy, O_done, O_xor
    );
endinterface

// File: rtl/mem_reader.sv
// Sweeps a wrap-around address range of the memory read port and streams
// the words out on valid/ready, keeping an XOR checksum of accepted words.
module mem_reader #(
    parameter int C_WORDSIZE = 8,
    parameter int C_MEMSIZE  = 4096,
    parameter int C_ADDRSIZE = $clog2(C_MEMSIZE)
) (
    input logic        I_clk,
    input logic        I_rst_n,
    mem_reader_if.master bus
);
    localparam logic [C_ADDRSIZE-1:0] LAST = C_ADDRSIZE'(C_MEMSIZE - 1);
    localparam logic [C_ADDRSIZE:0]   ONE  = (C_ADDRSIZE + 1)'(1);
    localparam logic [C_ADDRSIZE:0]   ZERO = '0;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [C_ADDRSIZE-1:0] addr;
    logic [C_ADDRSIZE:0]   remaining;
    logic [C_WORDSIZE-1:0] word;
    logic [C_WORDSIZE-1:0] xsum;
    logic                  valid;
    logic                  busy;
    logic                  done;
    logic                  accept;

    assign accept = valid && bus.I_ready;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            xsum      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (bus.I_abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (accept)
                xsum <= xsum ^ word;
            unique case (state)
                IDLE: begin
                    if (bus.I_start) begin
                        addr      <= bus.I_base;
                        remaining <= bus.I_len;
                        xsum      <= '0;
                        busy      <= 1'b1;
                        state     <= (bus.I_len != ZERO) ? READ : DONE;
                    end
                end
                READ: begin
                    if (!valid || bus.I_ready) begin
                        word      <= bus.I_rdata;
                        valid     <= 1'b1;
                        addr      <= (addr == LAST) ? '0 : addr + 1'b1;
                        remaining <= remaining - ONE;
                        if (remaining == ONE)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // An empty request arrives here with done low; it
                    // spends one cycle arming the pulse before leaving.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.O_addr  = addr;
    assign bus.O_word  = word;
    assign bus.O_valid = valid;
    assign bus.O_busy  = busy;
    assign bus.O_done  = done;
    assign bus.O_xor   = xsum;
endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: two instances (4096 and 3000 words),
// memories modelled as mem[a] = a[7:0].
module tb_mem_reader;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mem_reader_if #(.C_MEMSIZE(4096)) bus ();
    mem_reader_if #(.C_MEMSIZE(3000)) bus2 ();

    mem_reader #(.C_MEMSIZE(4096)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .bus(bus.master)
    );
    mem_reader #(.C_MEMSIZE(3000)) dut2 (
        .I_clk(clk), .I_rst_n(rst_n), .bus(bus2.master)
    );

    assign bus.I_rdata  = bus.O_addr[7:0];
    assign bus2.I_rdata = bus2.O_addr[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int base, input int len);
        bus.I_start = 1'b1;
        bus.I_base  = 12'(base);
        bus.I_len   = 13'(len);
        tick();
        bus.I_start = 1'b0;
    endtask

    // Runs a started request to completion, checking every accepted word.
    task automatic stream(input int base, input int len, input bit rnd);
        int         cnt;
        logic [7:0] xref;
        logic [7:0] pw;
        logic [7:0] ew;
        bit         pacc;
        bit         phold;
        bit         fin;
        cnt  = 0;
        xref = 8'h00;
        fin  = 0;
        bus.I_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 300 && !fin; c++) begin
            pacc  = bus.O_valid && bus.I_ready;
            phold = bus.O_valid && !bus.I_ready;
            pw    = bus.O_word;
            tick();
            if (pacc) begin
                ew = 8'((base + cnt) % 4096);
                chk("word", 32'(pw), 32'(ew));
                xref ^= ew;
                cnt++;
            end
            if (phold) begin
                chk("hold_valid", 32'(bus.O_valid), 32'd1);
                chk("hold_word", 32'(bus.O_word), 32'(pw));
            end
            if (bus.O_done) begin
                chk("count", cnt, len);
                chk("xor", 32'(bus.O_xor), 32'(xref));
                fin = 1;
            end
            bus.I_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!fin)
            chk("timeout", 32'd0, 32'd1);
        bus.I_ready = 1'b1;
        tick();
        chk("end_busy", 32'(bus.O_busy), 32'd0);
        chk("end_done", 32'(bus.O_done), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.I_start  = 1'b0;
        bus.I_base   = '0;
        bus.I_len    = '0;
        bus.I_abort  = 1'b0;
        bus.I_ready  = 1'b1;
        bus2.I_start = 1'b0;
        bus2.I_base  = '0;
        bus2.I_len   = '0;
        bus2.I_abort = 1'b0;
        bus2.I_ready = 1'b1;
        #12;
        chk("rst_addr", 32'(bus.O_addr), 32'd0);
        chk("rst_word", 32'(bus.O_word), 32'd0);
        chk("rst_valid", 32'(bus.O_valid), 32'd0);
        chk("rst_busy", 32'(bus.O_busy), 32'd0);
        chk("rst_done", 32'(bus.O_done), 32'd0);
        chk("rst_xor", 32'(bus.O_xor), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic 4-word read, exact timing
        start(16, 4);
        chk("t1_addr", 32'(bus.O_addr), 32'd16);
        chk("t1_busy", 32'(bus.O_busy), 32'd1);
        chk("t1_valid0", 32'(bus.O_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_valid", 32'(bus.O_valid), 32'd1);
            chk("t1_word", 32'(bus.O_word), 32'h10 + 32'(i));
            chk("t1_nodone", 32'(bus.O_done), 32'd0);
        end
        tick();
        chk("t1_done", 32'(bus.O_done), 32'd1);
        chk("t1_dbusy", 32'(bus.O_busy), 32'd1);
        chk("t1_dvalid", 32'(bus.O_valid), 32'd0);
        chk("t1_xor", 32'(bus.O_xor), 32'h00);
        tick();
        chk("t1_done_off", 32'(bus.O_done), 32'd0);
        chk("t1_idle", 32'(bus.O_busy), 32'd0);

        // Wrap at the top of a 4096-word memory
        start(4094, 4);
        stream(4094, 4, 0);

        // Wrap on a non power-of-two memory
        bus2.I_start = 1'b1;
        bus2.I_base  = 12'd2999;
        bus2.I_len   = 13'd2;
        tick();
        bus2.I_start = 1'b0;
        chk("w2_addr0", 32'(bus2.O_addr), 32'd2999);
        tick();
        chk("w2_word0", 32'(bus2.O_word), 32'hB7);
        chk("w2_addr1", 32'(bus2.O_addr), 32'd0);
        tick();
        chk("w2_word1", 32'(bus2.O_word), 32'h00);
        tick();
        chk("w2_done", 32'(bus2.O_done), 32'd1);
        chk("w2_xor", 32'(bus2.O_xor), 32'hB7);
        tick();

        // Random backpressure
        start(101, 8);
        stream(101, 8, 1);

        // Empty request
        start(55, 0);
        chk("z_valid0", 32'(bus.O_valid), 32'd0);
        chk("z_done0", 32'(bus.O_done), 32'd0);
        chk("z_busy0", 32'(bus.O_busy), 32'd1);
        tick();
        chk("z_done1", 32'(bus.O_done), 32'd1);
        chk("z_valid1", 32'(bus.O_valid), 32'd0);
        chk("z_xor", 32'(bus.O_xor), 32'd0);
        chk("z_addr", 32'(bus.O_addr), 32'd55);
        tick();
        chk("z_done2", 32'(bus.O_done), 32'd0);
        chk("z_busy2", 32'(bus.O_busy), 32'd0);

        // Abort after the 2nd accepted word
        start(200, 6);
        tick();
        tick();
        tick();
        bus.I_abort = 1'b1;
        tick();
        bus.I_abort = 1'b0;
        chk("ab_valid", 32'(bus.O_valid), 32'd0);
        chk("ab_busy", 32'(bus.O_busy), 32'd0);
        chk("ab_xor", 32'(bus.O_xor), 32'h01);
        chk("ab_addr", 32'(bus.O_addr), 32'd203);
        tick();
        chk("ab_nodone", 32'(bus.O_done), 32'd0);
        start(10, 3);
        stream(10, 3, 0);

        // Abort beats start in IDLE
        bus.I_abort = 1'b1;
        start(20, 2);
        bus.I_abort = 1'b0;
        chk("as_busy", 32'(bus.O_busy), 32'd0);

        // Start while busy is ignored, then async reset mid-READ
        start(300, 6);
        tick();
        bus.I_start = 1'b1;
        bus.I_base  = 12'd0;
        bus.I_len   = 13'd1;
        tick();
        bus.I_start = 1'b0;
        chk("sb_word", 32'(bus.O_word), 32'h2D);
        chk("sb_addr", 32'(bus.O_addr), 32'd302);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(bus.O_addr), 32'd0);
        chk("ar_word", 32'(bus.O_word), 32'd0);
        chk("ar_valid", 32'(bus.O_valid), 32'd0);
        chk("ar_busy", 32'(bus.O_busy), 32'd0);
        chk("ar_xor", 32'(bus.O_xor), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start(40, 3);
        stream(40, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_reader.md
# mem_reader

Sequential read-out engine for the response memory. On a start request it sweeps a contiguous, wrap-around address range of the memory's combinational read port. It streams each word out on a valid/ready handshake, accumulates an XOR checksum of the delivered words, and pulses done when the last word has been accepted. It sits between the memory's read side (`O_data`/`I_addr`) and the downstream readout/transport logic, and is the read-side counterpart of the memory's write port.

## Interface
- `C_WORDSIZE`, 8, memory word width in bits
- `C_MEMSIZE`, 4096, number of memory words; need not be a power of two
- `C_ADDRSIZE`, clog2(C_MEMSIZE), address width

Ports:
- `I_clk` input 1: single clock; all state updates on rising edge
- `I_rst_n` input 1: asynchronous, active-low reset
- `I_start` input 1: start request; sampled only in IDLE
- `I_base` input C_ADDRSIZE: first address, sampled with `I_start`; must be < C_MEMSIZE
- `I_len` input C_ADDRSIZE+1: number of words to read, sampled with `I_start`; range 0..C_MEMSIZE
- `I_abort` input 1: synchronous abort, has priority over everything except reset
- `O_addr` output C_ADDRSIZE: address to the memory read port
- `I_rdata` input C_WORDSIZE: memory read data, combinational from `O_addr`
- `O_word` output C_WORDSIZE: output data word
- `O_valid` output 1: `O_word` valid
- `I_ready` input 1: downstream accepts `O_word` when `O_valid && I_ready`
- `O_busy` output 1: high in any state other than IDLE
- `O_done` output 1: one-cycle pulse after the last word is accepted
- `O_xor` output C_WORDSIZE: XOR of all words accepted since the last start

## Operation
- States:
  - IDLE: wait for `I_start`.
  - READ: fetch words while any remain.
  - DRAIN: the last word is loaded; wait for it to be accepted.
  - DONE: assert `O_done` for one cycle, then go to IDLE.
- IDLE with `I_start`:
  - Load `O_addr<=I_base`, `remaining<=I_len`, `O_xor<=0`.
  - Go to READ if `I_len!=0`, else go to DONE directly. No word is emitted for `I_len=0`.
- READ: a load occurs when `!O_valid || I_ready`. On a load:
  - `O_word<=I_rdata`, `O_valid<=1`
  - `O_addr<=(O_addr==C_MEMSIZE-1)?0:O_addr+1`
  - `remaining<=remaining-1`
  - If this load takes `remaining` from 1 to 0, go to DRAIN.
- Any state: each accepted word (`O_valid && I_ready`) updates `O_xor<=O_xor^O_word` in the same edge.
- When `O_valid && !I_ready`, `O_word` and `O_valid` hold unchanged.
- DRAIN: on acceptance, `O_valid<=0` and go to DONE.
- DONE: `O_done=1` for exactly one cycle. `O_busy` stays 1 in this cycle. Next state is IDLE.
- `I_start` outside IDLE is ignored.
- `I_abort` in any non-IDLE state:
  - Next state is IDLE, `O_valid<=0`, no `O_done` pulse.
  - `O_xor` holds its partial value. `O_addr` holds.
- Memory contents must not change while `O_busy=1`. Words read after a concurrent write are undefined.
- `I_len=C_MEMSIZE` reads the whole memory exactly once, starting at `I_base` and wrapping.

## Timing
- Reset values: `O_addr=0`, `O_word=0`, `O_valid=0`, `O_busy=0`, `O_done=0`, `O_xor=0`, state IDLE, `remaining=0`.
- `I_start` sampled at edge k:
  - `O_addr=I_base` and `O_busy=1` after edge k.
  - First `O_valid=1` after edge k+1, carrying `mem[I_base]`.
- Throughput is one word per cycle while `I_ready=1`.
- With `I_ready` held at 1, N words complete as follows:
  - Last word is valid after edge k+N.
  - Accepted at edge k+N+1, which also enters DONE.
  - `O_done` is high for the cycle after edge k+N+1.
  - IDLE, with `O_busy=0`, after edge k+N+2.
- `I_len=0`: `O_done` is high after edge k+1, and IDLE follows after edge k+2.
- `O_xor` is final when `O_done` is high.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous). Operation resumes in IDLE after release.
- `I_start` and `I_abort` in the same IDLE cycle: abort wins, no start.

## Test plan
- Memory preloaded with `mem[a]=a[7:0]`, defaults, `I_base=16`, `I_len=4`, `I_ready=1`:
  - Words 0x10,0x11,0x12,0x13 on consecutive cycles.
  - `O_xor=0x00`, one `O_done` pulse, timing exactly as above.
- Wrap-around:
  - `I_base=4094`, `I_len=4` gives addresses 4094,4095,0,1 and words 0xFE,0xFF,0x00,0x01.
  - With `C_MEMSIZE=3000`, `I_base=2999`, `I_len=2` gives addresses 2999 then 0.
- Backpressure:
  - `I_ready` toggled randomly with an 8-word read.
  - `O_word` stable while `O_valid && !I_ready`; no words lost or duplicated.
  - `O_xor` equals the XOR reference; `O_done` appears only after the 8th acceptance.
- `I_len=0`:
  - No `O_valid`; `O_done` pulse after edge k+1.
  - `O_xor=0`, and `O_addr=I_base`.
- Abort after the 2nd accepted word of a 6-word read:
  - `O_valid` drops next cycle, no `O_done`, and `O_xor` holds the XOR of 2 words.
  - A subsequent start runs normally.
- Asynchronous reset mid-READ and `I_start` while busy:
  - Reset mid-READ: outputs go to reset values without a clock edge.
  - `I_start` pulsed during READ has no effect on the address sequence.
